mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one byte-wide, single-port external memory between the instruction-fetch port (`pc_reg`/`if_id` side) and the data port (`mem` stage) of the five-stage core. Each 32-bit access is serialised into four byte cycles. The assembled word or completion is returned to the winning requester. Stall requests are raised towards `ctrl` while a requester is waiting. The block sits between `binder` and the external RAM, replacing separate ROM/RAM buses.

## Interface
No parameters.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `if_req_i`  in  1  instruction fetch request, held until `if_done_o`
- `if_addr_i`  in  32  fetch address
- `if_data_o`  out  32  fetched word; valid with `if_done_o`, held until next IF grant
- `if_done_o`  out  1  one-cycle completion pulse for IF
- `mem_req_i`  in  1  data request, held until `mem_done_o`
- `mem_we_i`  in  1  1 = write, 0 = read
- `mem_sel_i`  in  4  byte-lane enables for writes (lane k = bits 8k+7:8k)
- `mem_addr_i`  in  32  data address
- `mem_data_i`  in  32  write data
- `mem_data_o`  out  32  read word; valid with `mem_done_o`, held until next MEM read grant
- `mem_done_o`  out  1  one-cycle completion pulse for MEM
- `stallreq_if_o`  out  1  `if_req_i & ~if_done_o`
- `stallreq_mem_o`  out  1  `mem_req_i & ~mem_done_o`
- `ext_addr_o`  out  32  byte address to external memory
- `ext_data_o`  out  8  byte write data
- `ext_we_o`  out  1  byte write strobe
- `ext_data_i`  in  8  read byte; registered memory, data for address of cycle N is valid in cycle N+1

## Operation
- States: IDLE, XFER (byte counter `cnt` 0..4), DONE.
- IDLE: grant MEM if `mem_req_i`, else IF if `if_req_i`. MEM always wins simultaneous requests.
- On grant, latch the owner, `we`, `sel` and write data. Latch base = {addr[31:2], 2'b00}. IF transactions are always reads.
- No preemption: the owner keeps the bus until its DONE.
- XFER read: cycles with `cnt` 0..3 drive `ext_addr_o` = base+cnt. Cycles with `cnt` 1..4 capture `ext_data_i` into lane `cnt`-1 (little-endian).
- XFER write: cycles with `cnt` 0..3 drive base+cnt and `ext_data_o` = lane `cnt`. `ext_we_o` = `sel[cnt]`. There is no capture cycle.
- DONE: pulse the owner's done output for one cycle, update its data register (reads only), then return to IDLE. Requests are not granted in DONE, so the requester can drop a stale `req`.
- Idle bus: `ext_addr_o` = 0, `ext_data_o` = 0, `ext_we_o` = 0.
- `stallreq_*_o` are combinational from the request and done signals.

## Timing
- Request first sampled in IDLE at cycle T.
- Read: byte addresses in T+1..T+4, captures at T+2..T+5, done in T+6. Earliest next grant is T+7.
- Write: byte cycles T+1..T+4, done in T+5.
- A losing requester is granted in the first IDLE cycle after the winner's DONE.
- Reset values:
  - state IDLE, `cnt` 0
  - `if_data_o` = `mem_data_o` = 0
  - both done outputs 0
  - all `ext_*_o` outputs 0
- Reset mid-transaction aborts it: `ext_we_o` is 0 in the cycle after the reset edge, and no done pulse is issued.
- A request dropped mid-transaction does not abort it; the done pulse is still issued.

## Configuration
- `ARB_WRITE_SKIP_EN` defined: writes issue only lanes with `sel` set, in ascending order, one per cycle. Done comes in the cycle after the last issued lane. With `sel` = 4'b0000, done is at T+1.
- `ARB_WRITE_SKIP_EN` undefined: writes always take four byte cycles, and lanes with `sel` clear have `ext_we_o` = 0.
- Reads are unaffected in both cases.

## Test plan
- IF read, addr 0x00000102, memory bytes 0x100..0x103 = 11,22,33,44:
  - `ext_addr_o` 0x100..0x103 in T+1..T+4
  - `if_done_o` in T+6 with `if_data_o` = 0x44332211
- MEM write, addr 0x200, data 0xAABBCCDD, sel 4'b1111: bytes DD,CC,BB,AA written to 0x200..0x203 in T+1..T+4, `mem_done_o` in T+5.
- MEM and IF requested in the same cycle: MEM served first; IF addresses appear from T+8 (read MEM) and IF done at T+13. `stallreq_if_o` stays high until then.
- Write with sel 4'b0100:
  - undefined macro: `ext_we_o` only in T+3 (addr base+2), done T+5
  - defined macro: `ext_we_o` only in T+1 at base+2, done T+2
- Reset asserted at T+3 of a write: IDLE next cycle, `ext_we_o` = 0 thereafter, no done pulse. A new IF request after reset completes normally in 6 cycles.
- Requester holds `req` through its DONE cycle: no second grant. `stallreq` is low in the DONE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one byte-wide external memory between the IF and MEM ports.
// Each 32-bit access becomes byte cycles. Optional feature macro: ARB_WRITE_SKIP_EN.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_done_o,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic [31:0] ext_addr_o,
    output logic [7:0]  ext_data_o,
    output logic        ext_we_o,
    input  logic [7:0]  ext_data_i
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_owner_mem;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic [29:0] r_base;
    logic [23:0] r_rbuf;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_data;
    logic        w_grant_mem;
    logic        w_grant_if;
    logic        w_bus_active;

`ifdef ARB_WRITE_SKIP_EN
    // Lowest enabled lane at or above 'from'; 4 means no lane remains.
    function automatic logic [2:0] next_lane(input logic [3:0] sel, input logic [2:0] from);
        logic [2:0] lane;
        lane = 3'd4;
        for (int k = 3; k >= 0; k--)
            if (sel[k] && (3'(k) >= from)) lane = 3'(k);
        return lane;
    endfunction
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_mem = mem_req_i;
                w_grant_if  = if_req_i & ~mem_req_i;
                if (mem_req_i || if_req_i) begin
                    w_state_nxt = S_XFER;
                    w_cnt_nxt   = 3'd0;
`ifdef ARB_WRITE_SKIP_EN
                    if (mem_req_i && mem_we_i) begin
                        w_cnt_nxt = next_lane(mem_sel_i, 3'd0);
                        if (w_cnt_nxt == 3'd4) begin
                            w_state_nxt = S_DONE;
                            w_cnt_nxt   = 3'd0;
                        end
                    end
`endif
                end
            end
            S_XFER: begin
                if (r_we) begin
`ifdef ARB_WRITE_SKIP_EN
                    w_cnt_nxt = next_lane(r_sel, r_cnt + 3'd1);
                    if (w_cnt_nxt == 3'd4) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = 3'd0;
                    end
`else
                    if (r_cnt == 3'd3) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
`endif
                end else if (r_cnt == 3'd4) begin
                    // Last read cycle only captures the byte addressed in the previous cycle.
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_owner_mem <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_wdata     <= 32'd0;
            r_base      <= 30'd0;
            r_rbuf      <= 24'd0;
            r_if_data   <= 32'd0;
            r_mem_data  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant_mem) begin
                r_owner_mem <= 1'b1;
                r_we        <= mem_we_i;
                r_sel       <= mem_sel_i;
                r_wdata     <= mem_data_i;
                r_base      <= mem_addr_i[31:2];
            end else if (w_grant_if) begin
                r_owner_mem <= 1'b0;
                r_we        <= 1'b0;
                r_sel       <= 4'd0;
                r_wdata     <= 32'd0;
                r_base      <= if_addr_i[31:2];
            end
            if (r_state == S_XFER && !r_we) begin
                case (r_cnt)
                    3'd1: r_rbuf[7:0]   <= ext_data_i;
                    3'd2: r_rbuf[15:8]  <= ext_data_i;
                    3'd3: r_rbuf[23:16] <= ext_data_i;
                    3'd4: begin
                        if (r_owner_mem) r_mem_data <= {ext_data_i, r_rbuf};
                        else             r_if_data  <= {ext_data_i, r_rbuf};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_bus_active   = (r_state == S_XFER) && !r_cnt[2];
    assign ext_addr_o     = w_bus_active ? {r_base, r_cnt[1:0]} : 32'd0;
    assign ext_data_o     = (w_bus_active && r_we) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;
    assign ext_we_o       = w_bus_active & r_we & r_sel[r_cnt[1:0]];
    assign if_done_o      = (r_state == S_DONE) & ~r_owner_mem;
    assign mem_done_o     = (r_state == S_DONE) & r_owner_mem;
    assign if_data_o      = r_if_data;
    assign mem_data_o     = r_mem_data;
    assign stallreq_if_o  = if_req_i & ~if_done_o;
    assign stallreq_mem_o = mem_req_i & ~mem_done_o;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: vector table plus directed sequences, then random traffic checked
// against a transaction-level timeline model and a shadow byte memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        mem_done_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic [31:0] ext_addr_o;
    logic [7:0]  ext_data_o;
    logic        ext_we_o;
    logic [7:0]  ext_data_i;

    logic        ram_fill = 1'b1;
    logic [7:0]  ram [0:4095];
    logic [7:0]  shadow [0:4095];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .mem_done_o(mem_done_o), .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .ext_addr_o(ext_addr_o), .ext_data_o(ext_data_o), .ext_we_o(ext_we_o),
        .ext_data_i(ext_data_i)
    );

    function automatic logic [7:0] init_byte(int a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    // External registered byte RAM: read data for cycle N's address appears in cycle N+1.
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
        end else if (ext_we_o) begin
            ram[ext_addr_o[11:0]] <= ext_data_o;
        end
        ext_data_i <= ram[ext_addr_o[11:0]];
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          done_off;
        logic [31:0] rdata;
        logic [15:0] we_mask;
        logic [31:0] addr1;
    } vec_t;

    function automatic vec_t mk(string n, logic m, logic w, logic [3:0] s, logic [31:0] a,
                                logic [31:0] d, int off, logic [31:0] rd, logic [15:0] wm,
                                logic [31:0] a1);
        vec_t v;
        v.name = n; v.is_mem = m; v.we = w; v.sel = s; v.addr = a; v.wdata = d;
        v.done_off = off; v.rdata = rd; v.we_mask = wm; v.addr1 = a1;
        return v;
    endfunction

    // Issue one transaction at cycle T and observe T..T+15; requester drops req after done.
    task automatic run_vec(vec_t v);
        int          done_at = -1;
        int          done_cnt = 0;
        int          other_cnt = 0;
        int          busy_after = 0;
        logic [15:0] we_seen = '0;
        logic [31:0] a1 = '0;
        logic [31:0] dval = '0;
        logic        stall_t = 1'b0;
        logic        stall_d = 1'b1;
        logic        my_done, other_done;
        @(posedge clk); #1;
        if (v.is_mem) begin
            mem_req_i = 1'b1; mem_we_i = v.we; mem_sel_i = v.sel;
            mem_addr_i = v.addr; mem_data_i = v.wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = v.addr;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (done_at >= 0 && k == done_at + 1) begin
                    if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
                end
            end
            @(negedge clk);
            my_done    = v.is_mem ? mem_done_o : if_done_o;
            other_done = v.is_mem ? if_done_o : mem_done_o;
            if (k == 0) stall_t = v.is_mem ? stallreq_mem_o : stallreq_if_o;
            if (k == 1) a1 = ext_addr_o;
            if (ext_we_o) we_seen[k] = 1'b1;
            if (other_done) other_cnt++;
            if (done_at >= 0 && (ext_addr_o != 32'd0 || ext_we_o)) busy_after++;
            if (my_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    dval    = v.is_mem ? mem_data_o : if_data_o;
                    stall_d = v.is_mem ? stallreq_mem_o : stallreq_if_o;
                end
            end
        end
        if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        check({v.name, " done cycle"}, 32'(done_at), 32'(v.done_off));
        check({v.name, " done count"}, 32'(done_cnt), 32'd1);
        check({v.name, " other done"}, 32'(other_cnt), 32'd0);
        check({v.name, " we cycles"}, 32'(we_seen), 32'(v.we_mask));
        check({v.name, " addr T+1"}, a1, v.addr1);
        check({v.name, " stall at T"}, 32'(stall_t), 32'd1);
        check({v.name, " stall at done"}, 32'(stall_d), 32'd0);
        check({v.name, " bus idle after done"}, 32'(busy_after), 32'd0);
        if (!v.we) check({v.name, " data"}, dval, v.rdata);
    endtask

    vec_t vecs[7];

    // Random-phase model state
    int          m_busy, m_done_at, m_owner_mem, m_we;
    logic [31:0] m_word, m_if_word, m_mem_word;
    int          if_act, mem_act, if_gap, mem_gap;
    logic        prev_if_done, prev_mem_done;
    logic        exp_if_done, exp_mem_done, done_now;

    initial begin
        int          mem_done_at, if_done_at, stall_ok, bad, dn;
        logic [31:0] a8, mdat, idat;
        logic        stall_done;

        for (int i = 0; i < 4096; i++) shadow[i] = init_byte(i);

        vecs[0] = mk("if read 0x102", 1'b0, 1'b0, 4'h0, 32'h102, 32'h0, 6, 32'h44332211, 16'h0, 32'h100);
        vecs[1] = mk("mem write 0x200", 1'b1, 1'b1, 4'hF, 32'h200, 32'hAABBCCDD, 5, 32'h0, 16'h001E, 32'h200);
        vecs[2] = mk("mem read 0x200", 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 6, 32'hAABBCCDD, 16'h0, 32'h200);
`ifdef ARB_WRITE_SKIP_EN
        vecs[3] = mk("write sel 0100", 1'b1, 1'b1, 4'b0100, 32'h300, 32'h12345678, 2, 32'h0, 16'h0002, 32'h302);
        vecs[5] = mk("write sel 0000", 1'b1, 1'b1, 4'b0000, 32'h400, 32'h87654321, 1, 32'h0, 16'h0, 32'h0);
`else
        vecs[3] = mk("write sel 0100", 1'b1, 1'b1, 4'b0100, 32'h300, 32'h12345678, 5, 32'h0, 16'h0008, 32'h300);
        vecs[5] = mk("write sel 0000", 1'b1, 1'b1, 4'b0000, 32'h400, 32'h87654321, 5, 32'h0, 16'h0, 32'h400);
`endif
        vecs[4] = mk("mem read 0x300", 1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 6, 32'h18340A03, 16'h0, 32'h300);
        vecs[6] = mk("if read 0x403", 1'b0, 1'b0, 4'h0, 32'h403, 32'h0, 6, 32'h18110A03, 16'h0, 32'h400);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset if_data", if_data_o, 32'd0);
        check("reset mem_data", mem_data_o, 32'd0);
        check("reset done", {30'd0, if_done_o, mem_done_o}, 32'd0);
        check("reset ext_addr", ext_addr_o, 32'd0);
        check("reset ext_data/we", {23'd0, ext_data_o, ext_we_o}, 32'd0);
        check("reset stall", {30'd0, stallreq_if_o, stallreq_mem_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ram_fill = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Simultaneous requests: MEM wins, IF follows after MEM's DONE.
        mem_done_at = -1; if_done_at = -1; stall_ok = 1; a8 = '0; mdat = '0; idat = '0;
        stall_done = 1'b1;
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100;
        if_req_i = 1'b1; if_addr_i = 32'h200;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (mem_done_at >= 0 && k == mem_done_at + 1) mem_req_i = 1'b0;
                if (if_done_at >= 0 && k == if_done_at + 1) if_req_i = 1'b0;
            end
            @(negedge clk);
            if (k == 8) a8 = ext_addr_o;
            if (mem_done_o && mem_done_at < 0) begin mem_done_at = k; mdat = mem_data_o; end
            if (if_done_o && if_done_at < 0) begin
                if_done_at = k; idat = if_data_o; stall_done = stallreq_if_o;
            end
            if (if_done_at < 0 && !stallreq_if_o) stall_ok = 0;
        end
        mem_req_i = 1'b0; if_req_i = 1'b0;
        check("both: mem done cycle", 32'(mem_done_at), 32'd6);
        check("both: mem data", mdat, 32'h44332211);
        check("both: if addr T+8", a8, 32'h200);
        check("both: if done cycle", 32'(if_done_at), 32'd13);
        check("both: if data", idat, 32'hAABBCCDD);
        check("both: if stall held", 32'(stall_ok), 32'd1);
        check("both: if stall at done", 32'(stall_done), 32'd0);

        // Reset in the middle of a write aborts it.
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
        mem_addr_i = 32'h500; mem_data_i = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        @(negedge clk);
        check("reset abort we", 32'(ext_we_o), 32'd0);
        check("reset abort mem_data", mem_data_o, 32'd0);
        check("reset abort if_data", if_data_o, 32'd0);
        bad = 0; dn = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (ext_we_o || ext_addr_o != 32'd0) bad++;
            if (mem_done_o || if_done_o) dn++;
        end
        check("reset abort bus quiet", 32'(bad), 32'd0);
        check("reset abort no done", 32'(dn), 32'd0);
        run_vec(vecs[0]);

        // Random traffic against a timeline model with a shadow memory.
        for (int i = 0; i < 4096; i++) shadow[i] = init_byte(i);
        @(posedge clk); #1 ram_fill = 1'b1;
        @(posedge clk); #1 ram_fill = 1'b0;
        m_busy = 0; m_done_at = 0; m_owner_mem = 0; m_we = 0; m_word = '0;
        m_if_word = 32'h44332211; m_mem_word = 32'd0;
        if_act = 0; mem_act = 0; if_gap = 0; mem_gap = 0;
        prev_if_done = 1'b0; prev_mem_done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (if_act != 0 && prev_if_done) begin
                if_act = 0; if_req_i = 1'b0; if_gap = int'($urandom_range(0, 3));
            end else if (if_act == 0) begin
                if (if_gap > 0) if_gap--;
                else if ($urandom_range(0, 1) == 1) begin
                    if_act = 1; if_req_i = 1'b1; if_addr_i = 32'($urandom_range(0, 127));
                end
            end
            if (mem_act != 0 && prev_mem_done) begin
                mem_act = 0; mem_req_i = 1'b0; mem_gap = int'($urandom_range(0, 3));
            end else if (mem_act == 0) begin
                if (mem_gap > 0) mem_gap--;
                else if ($urandom_range(0, 2) == 0) begin
                    mem_act = 1; mem_req_i = 1'b1;
                    mem_we_i = 1'($urandom_range(0, 1));
                    mem_sel_i = 4'($urandom);
                    mem_addr_i = 32'($urandom_range(0, 127));
                    mem_data_i = $urandom;
                end
            end
            @(negedge clk);
            done_now     = (m_busy != 0) && (cyc == m_done_at);
            exp_if_done  = done_now && (m_owner_mem == 0);
            exp_mem_done = done_now && (m_owner_mem != 0);
            if (exp_if_done) m_if_word = m_word;
            if (exp_mem_done && m_we == 0) m_mem_word = m_word;
            if (m_busy == 0 && (mem_req_i || if_req_i)) begin
                int b;
                m_busy = 1;
                m_owner_mem = mem_req_i ? 1 : 0;
                m_we = (mem_req_i && mem_we_i) ? 1 : 0;
                b = mem_req_i ? int'(mem_addr_i & 32'hFFC) : int'(if_addr_i & 32'hFFC);
                if (m_we != 0) begin
                    for (int l = 0; l < 4; l++)
                        if (mem_sel_i[l]) shadow[b + l] = mem_data_i[8*l +: 8];
`ifdef ARB_WRITE_SKIP_EN
                    m_done_at = cyc + 1 + $countones(mem_sel_i);
`else
                    m_done_at = cyc + 5;
`endif
                end else begin
                    m_word = {shadow[b + 3], shadow[b + 2], shadow[b + 1], shadow[b]};
                    m_done_at = cyc + 6;
                end
            end
            if (done_now) m_busy = 0;
            check("rand if_done", 32'(if_done_o), 32'(exp_if_done));
            check("rand mem_done", 32'(mem_done_o), 32'(exp_mem_done));
            check("rand stall_if", 32'(stallreq_if_o), 32'(if_req_i & ~exp_if_done));
            check("rand stall_mem", 32'(stallreq_mem_o), 32'(mem_req_i & ~exp_mem_done));
            check("rand if_data", if_data_o, m_if_word);
            check("rand mem_data", mem_data_o, m_mem_word);
            prev_if_done = if_done_o;
            prev_mem_done = mem_done_o;
        end
        @(posedge clk); #1;
        if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 32; w++)
            check("rand ram word", {ram[4*w+3], ram[4*w+2], ram[4*w+1], ram[4*w]},
                  {shadow[4*w+3], shadow[4*w+2], shadow[4*w+1], shadow[4*w]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
